bcd_gray_arbiter: RTL and testbench

BCD_GRAY_ARBITER -- requirements
Module: bcd_gray_arbiter

---
 rtl/bcd_gray_arbiter.sv | 147 ++++++++++++++
 tb/tb_bcd_gray_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_gray_arbiter.sv
// bcd_gray_arbiter: two requesters offer a BCD digit; a round-robin arbiter
// grants one at a time, the digit is converted to Gray code and held on the
// output until the consumer takes it. Per-requester completion counters.
// Optional feature macro: BCD_GRAY_ERR_CHECK_EN (flags digits above 9 on out_err).
//
// Handshake: a requester transfers its digit in a cycle where reqN_valid and
// reqN_ready are both high; the result transfers in a cycle where out_valid
// and out_ready are both high. Ready outputs never depend on a transfer that
// has not happened yet, and out_valid/out_gray/out_id/out_err stay stable
// until the result transfers.
module bcd_gray_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_bcd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_bcd,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [3:0]       out_gray,
  output logic             out_id,
  output logic             out_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       dig_q;
  logic             id_q;
  logic             last_q;    // requester that completed most recently
  logic             valid_q;
  logic [3:0]       gray_q;
  logic             oid_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             grant_vld;
  logic             grant_id;
  logic             accept;
  logic             done;

  // Arbitration: single requester wins outright, a tie goes to the one not served last
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_vld) state_d = S_CONVERT;
      S_CONVERT: state_d = S_HOLD;
      S_HOLD:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE (and never while reset is held), result handshake in HOLD
  always_comb begin
    accept     = (state_q == S_IDLE) && grant_vld && rst_n;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    done       = (state_q == S_HOLD) && out_ready;
  end

  // Datapath: capture on grant, convert in CONVERT, retire and count in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= 4'd0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      gray_q  <= 4'd0;
      oid_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      if (accept) begin
        dig_q <= grant_id ? req1_bcd : req0_bcd;
        id_q  <= grant_id;
      end
      if (state_q == S_CONVERT) begin
        gray_q  <= dig_q ^ {1'b0, dig_q[3:1]};
        oid_q   <= id_q;
        valid_q <= 1'b1;
      end
      if (done) begin
        valid_q <= 1'b0;
        last_q  <= oid_q;
        if (oid_q) begin
          cnt1_q <= cnt1_q + CNT_W'(1);
        end else begin
          cnt0_q <= cnt0_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef BCD_GRAY_ERR_CHECK_EN
  logic err_q;

  // Error flag: digit outside 0..9, registered alongside the Gray result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == S_CONVERT) begin
      err_q <= (dig_q > 4'd9);
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid = valid_q;
  assign out_gray  = gray_q;
  assign out_id    = oid_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_bcd_gray_arbiter.sv
// Bench for bcd_gray_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all checked against a transaction-level model.
module tb_bcd_gray_arbiter;

  localparam int CNT_W = 2;
`ifdef BCD_GRAY_ERR_CHECK_EN
  localparam logic ERR12 = 1'b1;
`else
  localparam logic ERR12 = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic [3:0]       req0_bcd = 4'd0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [3:0]       req1_bcd = 4'd0;
  logic             req1_ready;
  logic             out_valid;
  logic [3:0]       out_gray;
  logic             out_id;
  logic             out_err;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [1:0]       state_o;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  bcd_gray_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_bcd(req0_bcd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_bcd(req1_bcd), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_gray(out_gray), .out_id(out_id), .out_err(out_err),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One conversion in flight at a time; the result appears two cycles after
  // the cycle in which the digit was accepted and leaves on out_ready.
  bit         m_busy = 0;
  int         m_acc = 0;
  int         m_last = 1;
  int         m_cnt[2] = '{0, 0};
  int         cyc = 0;
  logic [5:0] exp_q[$];   // {id, err, gray}

  function automatic logic exp_err(input logic [3:0] d);
`ifdef BCD_GRAY_ERR_CHECK_EN
    return d > 4'd9;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_grant();
    if (m_busy || !rst_n) return -1;
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    logic [3:0] d;
    logic [5:0] e;
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0; cyc = 0;
      exp_q.delete();
    end else begin
      if (m_busy) begin
        if (cyc >= m_acc + 2 && out_ready) begin
          e = exp_q.pop_front();
          m_busy = 0;
          m_last = int'(e[5]);
          m_cnt[e[5]] = (m_cnt[e[5]] + 1) % (1 << CNT_W);
        end
      end else begin
        g = exp_grant();
        if (g >= 0) begin
          d = (g == 1) ? req1_bcd : req0_bcd;
          m_busy = 1;
          m_acc = cyc;
          exp_q.push_back({g[0], exp_err(d), d ^ (d >> 1)});
        end
      end
      cyc++;
    end
  end

  // compare process: every cycle, on the falling edge
  always @(negedge clk) begin
    int g;
    bit ev;
    if (chk_on) begin
      g  = exp_grant();
      ev = m_busy && (cyc >= m_acc + 2);
      chk("m_ready0", req0_ready, (g == 0));
      chk("m_ready1", req1_ready, (g == 1));
      chk("m_out_valid", out_valid, ev);
      if (ev && exp_q.size() > 0) begin
        chk("m_out_gray", out_gray, exp_q[0][3:0]);
        chk("m_out_id", out_id, exp_q[0][5]);
        chk("m_out_err", out_err, exp_q[0][4]);
      end
      chk("m_cnt0", cnt0, m_cnt[0]);
      chk("m_cnt1", cnt1, m_cnt[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_bcd = 0; req1_bcd = 0; out_ready = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 0;
    idle_inputs();
    req0_valid = 1; req0_bcd = 4'd3;   // a request during reset must not be granted
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gray", out_gray, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    req0_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    int ok;
    #1;
    chk_on = 1;

    // single conversion on requester 0
    reset_dut();
    req0_valid = 1; req0_bcd = 4'd5; out_ready = 1;
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk);
    chk("t1_conv_valid", out_valid, 0);
    chk("t1_conv_ready0", req0_ready, 0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_gray", out_gray, 4'b0111);
    chk("t1_id", out_id, 0);
    @(negedge clk);
    chk("t1_valid_clr", out_valid, 0);
    chk("t1_cnt0", cnt0, 1);

    // round-robin order with both requesters always valid
    reset_dut();
    req0_valid = 1; req0_bcd = 4'd1; req1_valid = 1; req1_bcd = 4'd2; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int t = 0; t < 8 && !ok; t++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) ok = 1;
      end
      chk("rr_timeout", ok, 1);
      chk("rr_order", req1_ready, k % 2);
      chk("rr_both", req0_ready & req1_ready, 0);
    end
    drain();

    // result held while out_ready is low
    reset_dut();
    req0_valid = 1; req0_bcd = 4'd9; out_ready = 0;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 1; req1_bcd = 4'd2;
    @(negedge clk);
    chk("t3_conv_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_gray", out_gray, 4'b1101);
      chk("t3_hold_ready1", req1_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("t3_rel_valid", out_valid, 0);
    chk("t3_rel_ready1", req1_ready, 1);
    chk("t3_rel_cnt0", cnt0, 1);
    @(posedge clk); #1;
    drain();

    // out-of-range digit on requester 1
    reset_dut();
    req1_valid = 1; req1_bcd = 4'd12; out_ready = 1;
    @(posedge clk); #1; req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid", out_valid, 1);
    chk("t4_gray", out_gray, 4'b1010);
    chk("t4_id", out_id, 1);
    chk("t4_err", out_err, ERR12);
    @(negedge clk);
    chk("t4_cnt1", cnt1, 1);

    // reset pulse while a result is held
    reset_dut();
    req1_valid = 1; req1_bcd = 4'd3; out_ready = 1;
    @(posedge clk); #1; req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("t5_pre_cnt1", cnt1, 1);
    out_ready = 0; req0_valid = 1; req0_bcd = 4'd7;
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_hold_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_cnt1", cnt1, 0);
    chk("t5_async_cnt0", cnt0, 0);
    req0_valid = 1; req1_valid = 1;
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    chk("t5_grant0", req0_ready, 1);
    chk("t5_grant1", req1_ready, 0);
    @(posedge clk); #1;
    drain();

    // counter wrap: five conversions on requester 1 with CNT_W=2
    reset_dut();
    req1_valid = 1; req1_bcd = 4'd4; out_ready = 1;
    seen = 0;
    for (int t = 0; t < 40 && seen < 5; t++) begin
      @(negedge clk);
      if (req1_ready) seen++;
    end
    chk("t6_grants", seen, 5);
    @(posedge clk); #1; req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("t6_cnt1", cnt1, 1);
    chk("t6_cnt0", cnt0, 0);

    // randomized traffic
    reset_dut();
    for (int i = 0; i < 2000; i++) begin
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      req0_bcd   = 4'($urandom_range(0, 15));
      req1_bcd   = 4'($urandom_range(0, 15));
      out_ready  = ($urandom_range(0, 9) < 7);
      if (i == 1000) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
      @(posedge clk); #1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
